uart_rx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_sync_edge.sv | 32 +++
 rtl/uart_rx_fifo.sv | 90 +++++++++
 tb/tb_uart_rx_fifo.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART block family.
package uart_pkg;

  localparam int UART_BYTE_W           = 8;
  localparam int RX_FIFO_DEPTH_DEFAULT = 16;

endpackage

// File: rtl/uart_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector; emits one clk-wide
// pulse per rising edge of an asynchronous level.
module uart_sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);

  logic s1;
  logic s2;
  logic s3;

  // NOTE: resetting all three flops to RST_VAL means a level already high at
  // reset release looks "old" and never produces a pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
      s3 <= RST_VAL;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse = s2 & ~s3;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte FIFO: re-times the UART strobe into clk, pushes each
// byte once, and serves a valid/ready consumer with sticky overflow.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH  = RX_FIFO_DEPTH_DEFAULT,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [UART_BYTE_W-1:0] rx_data,
  input  logic                   rx_we,
  output logic                   rd_valid,
  output logic [UART_BYTE_W-1:0] rd_data,
  input  logic                   rd_ready,
  output logic [ADDR_W:0]        count,
  output logic                   overflow,
  input  logic                   clr_overflow
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("uart_rx_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic                   push_req;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic [ADDR_W-1:0]      rd_ptr;
  logic [ADDR_W-1:0]      wr_ptr;
  logic [UART_BYTE_W-1:0] mem [DEPTH];

  uart_sync_edge #(
    .RST_VAL (1'b1)
  ) u_we_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (rx_we),
    .pulse    (push_req)
  );

  // rd_valid derives only from the count register, so rd_ready never reaches it.
  assign rd_valid = (count != '0);
  assign full     = (count == FULL_CNT);
  assign pop      = rd_valid & rd_ready;
  assign push     = push_req & (~full | pop);
  assign rd_data  = mem[rd_ptr];

  // NOTE: storage has no reset; contents are meaningless until written and
  // rd_valid masks them, so a reset here would only cost flops.
  // rx_data is taken unsynchronized: it has been stable for two cycles by the
  // time push_req fires.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // A dropped byte takes priority over a clear arriving in the same cycle.
      if (push_req & ~push) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized
// traffic, all compared every cycle against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_we;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_ready;
  logic [4:0] count;
  logic       overflow;
  logic       clr_overflow;

  always #5 clk = ~clk;

  uart_rx_fifo dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_we        (rx_we),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_ready     (rd_ready),
    .count        (count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue, plus a list of cycles at which a pending
  // strobe edge turns into a write attempt (two edges after it is first seen).
  logic [7:0] mq[$];
  int         due[$];
  logic [7:0] got[$];
  int         cyc      = 0;
  bit         prev_we  = 1'b1;
  bit         m_ov     = 1'b0;
  bit         model_on = 1'b0;
  int         max_cnt  = 0;

  always @(posedge clk) begin
    bit m_req;
    bit m_pop;
    bit m_push;
    cyc++;
    if (rst_n && rd_valid && rd_ready) got.push_back(rd_data);
    if (!rst_n) begin
      mq.delete();
      due.delete();
      prev_we = 1'b1;
      m_ov    = 1'b0;
    end else begin
      m_req = (due.size() > 0) && (due[0] == cyc);
      if (m_req) void'(due.pop_front());
      m_pop  = (mq.size() > 0) && rd_ready;
      m_push = m_req && ((mq.size() < DEPTH) || m_pop);
      if (m_pop)  void'(mq.pop_front());
      if (m_push) mq.push_back(rx_data);
      if (m_req && !m_push) m_ov = 1'b1;
      else if (clr_overflow) m_ov = 1'b0;
      if (rx_we && !prev_we) due.push_back(cyc + 2);
      prev_we = rx_we;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("rd_valid", 32'(rd_valid), 32'(mq.size() != 0));
      check("count", 32'(count), 32'(mq.size()));
      check("overflow", 32'(overflow), 32'(m_ov));
      if (mq.size() != 0) check("rd_data", 32'(rd_data), 32'(mq[0]));
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
  end

  bit rand_mode  = 1'b0;
  int ready_pct  = 50;

  task automatic step(input int n);
    repeat (n) begin
      if (rand_mode) begin
        rd_ready     = ($urandom_range(99) < ready_pct);
        clr_overflow = ($urandom_range(15) == 0);
      end
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hi, input int lo);
    rx_data = b;
    rx_we   = 1'b1;
    step(hi);
    rx_we   = 1'b0;
    step(lo);
  endtask

  initial begin
    logic [7:0] exp_seq[$];
    rst_n        = 1'b0;
    rx_data      = 8'h00;
    rx_we        = 1'b0;
    rd_ready     = 1'b0;
    clr_overflow = 1'b0;
    step(3);
    check("reset_valid", 32'(rd_valid), 32'd0);
    check("reset_count", 32'(count), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    rst_n    = 1'b1;
    model_on = 1'b1;
    step(2);

    // Single byte with a long strobe: write on the third edge, once only.
    rx_data = 8'hA5;
    rx_we   = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("single_not_yet", 32'(rd_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("single_valid", 32'(rd_valid), 32'd1);
    check("single_data", 32'(rd_data), 32'hA5);
    check("single_count", 32'(count), 32'd1);
    @(posedge clk);
    #2;
    step(196);
    check("single_no_repeat", 32'(count), 32'd1);
    rx_we    = 1'b0;
    rd_ready = 1'b1;
    step(1);
    rd_ready = 1'b0;
    step(2);

    // Ordering and pointer wrap with a consumer that is always ready.
    got.delete();
    max_cnt  = 0;
    rd_ready = 1'b1;
    for (int i = 0; i < 40; i++) send_byte(8'(i), 3, 2);
    step(5);
    check("order_len", 32'(got.size()), 32'd40);
    for (int i = 0; i < 40 && i < got.size(); i++) check("order_byte", 32'(got[i]), 32'(i));
    check("order_max_count", 32'(max_cnt), 32'd1);
    check("order_overflow", 32'(overflow), 32'd0);
    rd_ready = 1'b0;

    // Overflow: 17 bytes into 16 entries.
    for (int i = 0; i < 17; i++) send_byte(8'(8'h10 + i), 3, 2);
    check("ovf_count", 32'(count), 32'd16);
    check("ovf_flag", 32'(overflow), 32'd1);
    clr_overflow = 1'b1;
    step(1);
    clr_overflow = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Full FIFO: push of 0x55 lands on the same edge as a pop.
    got.delete();
    rx_data = 8'h55;
    rx_we   = 1'b1;
    step(2);
    rd_ready = 1'b1;
    step(1);
    rd_ready = 1'b0;
    check("simul_count", 32'(count), 32'd16);
    check("simul_overflow", 32'(overflow), 32'd0);
    step(2);
    rx_we = 1'b0;
    step(2);
    rd_ready = 1'b1;
    step(20);
    rd_ready = 1'b0;
    for (int i = 0; i < 16; i++) exp_seq.push_back(8'(8'h10 + i));
    exp_seq.push_back(8'h55);
    check("simul_len", 32'(got.size()), 32'd17);
    for (int i = 0; i < 17 && i < got.size(); i++) check("simul_byte", 32'(got[i]), 32'(exp_seq[i]));

    // Set beats clear when a drop and clr_overflow coincide.
    for (int i = 0; i < 16; i++) send_byte(8'(8'h80 + i), 3, 2);
    rx_data = 8'hEE;
    rx_we   = 1'b1;
    step(2);
    clr_overflow = 1'b1;
    step(1);
    clr_overflow = 1'b0;
    check("prio_set_wins", 32'(overflow), 32'd1);
    rx_we = 1'b0;
    step(2);
    clr_overflow = 1'b1;
    step(1);
    clr_overflow = 1'b0;
    check("prio_clear_alone", 32'(overflow), 32'd0);

    // Strobe held high across reset release never pushes.
    rx_we = 1'b1;
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(8);
    check("rst_held_count", 32'(count), 32'd0);
    rx_we = 1'b0;
    step(3);

    // One-cycle reset with 5 bytes stored and a strobe in flight.
    for (int i = 0; i < 5; i++) send_byte(8'(8'hC0 + i), 3, 2);
    check("rst_pre_count", 32'(count), 32'd5);
    rx_data = 8'hDD;
    rx_we   = 1'b1;
    step(1);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check("rst_mid_valid", 32'(rd_valid), 32'd0);
    check("rst_mid_count", 32'(count), 32'd0);
    check("rst_mid_overflow", 32'(overflow), 32'd0);
    step(4);
    check("rst_inflight_dropped", 32'(count), 32'd0);
    rx_we = 1'b0;
    step(3);

    // Randomized traffic with varying consumer throughput.
    rand_mode = 1'b1;
    for (int epoch = 0; epoch < 6; epoch++) begin
      ready_pct = (epoch % 3 == 0) ? 10 : ((epoch % 3 == 1) ? 50 : 90);
      for (int i = 0; i < 50; i++) begin
        send_byte(8'($urandom), int'($urandom_range(1, 6)), int'($urandom_range(1, 6)));
      end
    end
    rand_mode    = 1'b0;
    clr_overflow = 1'b0;
    rd_ready     = 1'b1;
    step(40);
    check("final_empty", 32'(count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
